// File: rtl/vx_bypass_dram_sched.sv
// Uncached bypass scheduler: round-robin lane arbitration onto one DRAM port,
// outstanding-read tag table, response routing and flush drain. Optional perf counters: VX_BYPASS_PERF_EN.
module vx_bypass_dram_sched #(
  parameter int NUM_REQS        = 4,
  parameter int WORD_SIZE       = 4,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int MSHR_SIZE       = 8,
  parameter int CORE_TAG_WIDTH  = 3,
  localparam int WOFF  = $clog2(CACHE_LINE_SIZE / WORD_SIZE),
  localparam int WAW   = 32 - $clog2(WORD_SIZE),
  localparam int DAW   = WAW - WOFF,
  localparam int DTW   = $clog2(MSHR_SIZE),
  localparam int WBITS = 8 * WORD_SIZE,
  localparam int LBITS = 8 * CACHE_LINE_SIZE
) (
  input  logic                               clk,
  input  logic                               reset,
`ifdef VX_BYPASS_PERF_EN
  output logic [31:0]                        perf_reads,
  output logic [31:0]                        perf_writes,
  output logic [31:0]                        perf_stalls,
`endif
  input  logic                               flush,
  output logic                               busy,
  input  logic [NUM_REQS-1:0]                core_req_valid,
  input  logic [NUM_REQS-1:0]                core_req_rw,
  input  logic [NUM_REQS*WAW-1:0]            core_req_addr,
  input  logic [NUM_REQS*WORD_SIZE-1:0]      core_req_byteen,
  input  logic [NUM_REQS*WBITS-1:0]          core_req_data,
  input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0] core_req_tag,
  output logic [NUM_REQS-1:0]                core_req_ready,
  output logic [NUM_REQS-1:0]                core_rsp_valid,
  output logic [NUM_REQS*WBITS-1:0]          core_rsp_data,
  output logic [NUM_REQS*CORE_TAG_WIDTH-1:0] core_rsp_tag,
  input  logic [NUM_REQS-1:0]                core_rsp_ready,
  output logic                               dram_req_valid,
  output logic                               dram_req_rw,
  output logic [CACHE_LINE_SIZE-1:0]         dram_req_byteen,
  output logic [DAW-1:0]                     dram_req_addr,
  output logic [LBITS-1:0]                   dram_req_data,
  output logic [DTW-1:0]                     dram_req_tag,
  input  logic                               dram_req_ready,
  input  logic                               dram_rsp_valid,
  input  logic [LBITS-1:0]                   dram_rsp_data,
  input  logic [DTW-1:0]                     dram_rsp_tag,
  output logic                               dram_rsp_ready
);

  localparam int LW    = $clog2(NUM_REQS);
  localparam int WORDS = CACHE_LINE_SIZE / WORD_SIZE;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [LW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [MSHR_SIZE-1:0]      ent_vld_q, ent_vld_d;
  logic [LW-1:0]             ent_lane_q [MSHR_SIZE];
  logic [LW-1:0]             ent_lane_d [MSHR_SIZE];
  logic [CORE_TAG_WIDTH-1:0] ent_tag_q  [MSHR_SIZE];
  logic [CORE_TAG_WIDTH-1:0] ent_tag_d  [MSHR_SIZE];
  logic [WOFF-1:0]           ent_off_q  [MSHR_SIZE];
  logic [WOFF-1:0]           ent_off_d  [MSHR_SIZE];

  logic                      rsp_vld_q, rsp_vld_d;
  logic [LW-1:0]             rsp_lane_q, rsp_lane_d;
  logic [CORE_TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic [DTW-1:0]            rsp_idx_q, rsp_idx_d;
  logic [WBITS-1:0]          rsp_data_q, rsp_data_d;

  logic [NUM_REQS-1:0]       elig;
  logic                      mshr_full;
  logic                      gnt_found;
  logic [LW-1:0]             gnt_idx, cand;
  logic [DTW-1:0]            free_idx;
  logic                      sel_rw;
  logic [WAW-1:0]            sel_addr;
  logic [WOFF-1:0]           sel_off;
  logic [WORD_SIZE-1:0]      sel_be;
  logic [WBITS-1:0]          sel_data;
  logic [CORE_TAG_WIDTH-1:0] sel_tag;
  logic                      issue, rsp_fire, core_hs;

  assign mshr_full = &ent_vld_q;

  // Arbitration: reads are ineligible while the table is full so writes can still pass.
  always_comb begin
    elig      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQS; i++)
      elig[i] = core_req_valid[i] & (core_req_rw[i] | ~mshr_full);
    for (int i = 1; i <= NUM_REQS; i++) begin
      cand = rr_ptr_q + LW'(i);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = MSHR_SIZE - 1; i >= 0; i--)
      if (!ent_vld_q[i]) free_idx = DTW'(i);
  end

  always_comb begin
    sel_rw   = core_req_rw[gnt_idx];
    sel_addr = core_req_addr[32'(gnt_idx) * WAW +: WAW];
    sel_off  = sel_addr[WOFF-1:0];
    sel_be   = core_req_byteen[32'(gnt_idx) * WORD_SIZE +: WORD_SIZE];
    sel_data = core_req_data[32'(gnt_idx) * WBITS +: WBITS];
    sel_tag  = core_req_tag[32'(gnt_idx) * CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
  end

  // A flush pulse suppresses issue in its own cycle, before the FSM reaches DRAIN.
  assign dram_req_valid  = (state_q == ST_IDLE) & ~flush & gnt_found;
  assign dram_req_rw     = sel_rw;
  assign dram_req_addr   = sel_addr[WAW-1:WOFF];
  assign dram_req_byteen = CACHE_LINE_SIZE'(sel_be) << (32'(sel_off) * WORD_SIZE);
  assign dram_req_data   = {WORDS{sel_data}};
  assign dram_req_tag    = sel_rw ? '0 : free_idx;
  assign issue           = dram_req_valid & dram_req_ready;
  assign core_req_ready  = issue ? (NUM_REQS'(1) << gnt_idx) : '0;

  assign dram_rsp_ready  = ~rsp_vld_q;
  assign rsp_fire        = dram_rsp_valid & ~rsp_vld_q;
  assign core_hs         = rsp_vld_q & core_rsp_ready[rsp_lane_q];
  assign core_rsp_valid  = rsp_vld_q ? (NUM_REQS'(1) << rsp_lane_q) : '0;
  assign core_rsp_data   = {NUM_REQS{rsp_data_q}};
  assign core_rsp_tag    = {NUM_REQS{rsp_tag_q}};
  assign busy            = (state_q == ST_DRAIN);

  always_comb begin
    rr_ptr_d   = issue ? gnt_idx : rr_ptr_q;
    ent_vld_d  = ent_vld_q;
    ent_lane_d = ent_lane_q;
    ent_tag_d  = ent_tag_q;
    ent_off_d  = ent_off_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_lane_d = rsp_lane_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_data_d = rsp_data_q;
    if (issue && !sel_rw) begin
      ent_vld_d[free_idx]  = 1'b1;
      ent_lane_d[free_idx] = gnt_idx;
      ent_tag_d[free_idx]  = sel_tag;
      ent_off_d[free_idx]  = sel_off;
    end
    if (core_hs) begin
      ent_vld_d[rsp_idx_q] = 1'b0;
      rsp_vld_d            = 1'b0;
    end
    // Responses for entries that are not live (e.g. issued before a reset) are swallowed.
    if (rsp_fire && ent_vld_q[dram_rsp_tag]) begin
      rsp_vld_d  = 1'b1;
      rsp_lane_d = ent_lane_q[dram_rsp_tag];
      rsp_tag_d  = ent_tag_q[dram_rsp_tag];
      rsp_idx_d  = dram_rsp_tag;
      rsp_data_d = dram_rsp_data[32'(ent_off_q[dram_rsp_tag]) * WBITS +: WBITS];
    end
  end

  // Drain exit looks at next-state occupancy so busy drops right after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (ent_vld_d == '0 && !rsp_vld_d) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= LW'(NUM_REQS - 1);
      ent_vld_q <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ent_vld_q <= ent_vld_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_lane_q <= ent_lane_d;
    ent_tag_q  <= ent_tag_d;
    ent_off_q  <= ent_off_d;
    rsp_lane_q <= rsp_lane_d;
    rsp_tag_q  <= rsp_tag_d;
    rsp_idx_q  <= rsp_idx_d;
    rsp_data_q <= rsp_data_d;
  end

`ifdef VX_BYPASS_PERF_EN
  logic [31:0] perf_reads_q, perf_reads_d;
  logic [31:0] perf_writes_q, perf_writes_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_reads_d  = perf_reads_q  + 32'(issue & ~sel_rw);
    perf_writes_d = perf_writes_q + 32'(issue & sel_rw);
    perf_stalls_d = perf_stalls_q + 32'((|core_req_valid) & ~issue);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_bypass_dram_sched.sv
// Directed self-checking bench for vx_bypass_dram_sched (default configuration).
module tb_vx_bypass_dram_sched;

  localparam int NR = 4;
  localparam int WAW = 30;
  localparam int DAW = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          busy;
  logic [NR-1:0] core_req_valid, core_req_rw, core_req_ready;
  logic [NR*WAW-1:0] core_req_addr;
  logic [NR*4-1:0]   core_req_byteen;
  logic [NR*32-1:0]  core_req_data;
  logic [NR*3-1:0]   core_req_tag;
  logic [NR-1:0]     core_rsp_valid, core_rsp_ready;
  logic [NR*32-1:0]  core_rsp_data;
  logic [NR*3-1:0]   core_rsp_tag;
  logic          dram_req_valid, dram_req_rw, dram_req_ready;
  logic [63:0]   dram_req_byteen;
  logic [DAW-1:0] dram_req_addr;
  logic [511:0]  dram_req_data;
  logic [2:0]    dram_req_tag;
  logic          dram_rsp_valid, dram_rsp_ready;
  logic [511:0]  dram_rsp_data;
  logic [2:0]    dram_rsp_tag;

  int n_cmp = 0;
  int n_bad = 0;

  vx_bypass_dram_sched dut (
    .clk(clk), .reset(reset), .flush(flush), .busy(busy),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_addr(core_req_addr), .core_req_byteen(core_req_byteen),
    .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
    .dram_req_valid(dram_req_valid), .dram_req_rw(dram_req_rw),
    .dram_req_byteen(dram_req_byteen), .dram_req_addr(dram_req_addr),
    .dram_req_data(dram_req_data), .dram_req_tag(dram_req_tag),
    .dram_req_ready(dram_req_ready),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data),
    .dram_rsp_tag(dram_rsp_tag), .dram_rsp_ready(dram_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic v, input logic rw, input logic [WAW-1:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic [2:0] t);
    core_req_valid[l]         = v;
    core_req_rw[l]            = rw;
    core_req_addr[l*WAW +: WAW] = a;
    core_req_byteen[l*4 +: 4] = be;
    core_req_data[l*32 +: 32] = d;
    core_req_tag[l*3 +: 3]    = t;
  endtask

  // Present one DRAM response for a cycle; returns one step after the accepting edge.
  task automatic do_rsp(input logic [2:0] t, input logic [31:0] base);
    dram_rsp_valid = 1'b1;
    dram_rsp_tag   = t;
    for (int k = 0; k < 16; k++) dram_rsp_data[k*32 +: 32] = base + 32'(k);
    tick();
    dram_rsp_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    core_req_valid = '0; core_req_rw = '0; core_req_addr = '0;
    core_req_byteen = '0; core_req_data = '0; core_req_tag = '0;
    core_rsp_ready = '0; dram_req_ready = 1'b1;
    dram_rsp_valid = 1'b0; dram_rsp_data = '0; dram_rsp_tag = '0;
    do_reset();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_rsp_valid", 64'(core_rsp_valid), 64'd0);
    chk("rst_dram_rsp_ready", 64'(dram_rsp_ready), 64'd1);
    chk("rst_dram_req_valid", 64'(dram_req_valid), 64'd0);

    // Single read from lane 2
    set_lane(2, 1'b1, 1'b0, 30'h13, 4'hF, 32'hDEADBEEF, 3'd5);
    #1;
    chk("rd_valid", 64'(dram_req_valid), 64'd1);
    chk("rd_ready", 64'(core_req_ready), 64'h4);
    chk("rd_addr", 64'(dram_req_addr), 64'h1);
    chk("rd_byteen", dram_req_byteen, 64'hF000);
    chk("rd_tag", 64'(dram_req_tag), 64'd0);
    chk("rd_data_lo", 64'(dram_req_data[31:0]), 64'hDEADBEEF);
    chk("rd_data_hi", 64'(dram_req_data[511:480]), 64'hDEADBEEF);
    tick();
    set_lane(2, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    chk("rd_pre_rsp_valid", 64'(core_rsp_valid), 64'd0);
    do_rsp(3'd0, 32'hA000_0000);
    chk("rd_rsp_valid", 64'(core_rsp_valid), 64'h4);
    chk("rd_rsp_tag", 64'(core_rsp_tag[8:6]), 64'd5);
    chk("rd_rsp_data", 64'(core_rsp_data[95:64]), 64'hA000_0003);
    chk("rd_rsp_busy_reg", 64'(dram_rsp_ready), 64'd0);
    tick();
    chk("rd_rsp_hold", 64'(core_rsp_valid), 64'h4);
    core_rsp_ready = 4'hF;
    tick();
    chk("rd_rsp_done", 64'(core_rsp_valid), 64'd0);
    chk("rd_rsp_free", 64'(dram_rsp_ready), 64'd1);

    // Round-robin over four writing lanes
    do_reset();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 1'b1, 30'(l), 4'hF, 32'(l), '0);
    #1;
    chk("rr_g0", 64'(core_req_ready), 64'h1); tick();
    chk("rr_g1", 64'(core_req_ready), 64'h2); tick();
    chk("rr_g2", 64'(core_req_ready), 64'h4); tick();
    chk("rr_g3", 64'(core_req_ready), 64'h8); tick();
    chk("rr_g4", 64'(core_req_ready), 64'h1);
    chk("rr_wr_tag", 64'(dram_req_tag), 64'd0);
    core_req_valid = '0;

    // MSHR full
    do_reset();
    set_lane(0, 1'b1, 1'b0, 30'h0, 4'hF, 32'h1111, 3'd0);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("full_alloc_tag", 64'(dram_req_tag), 64'(i));
      chk("full_alloc_gnt", 64'(core_req_ready), 64'h1);
      tick();
    end
    chk("full_blocked_gnt", 64'(core_req_ready), 64'd0);
    chk("full_blocked_valid", 64'(dram_req_valid), 64'd0);
    set_lane(1, 1'b1, 1'b1, 30'h40, 4'h3, 32'h2222, 3'd0);
    #1;
    chk("full_wr_gnt", 64'(core_req_ready), 64'h2);
    chk("full_wr_rw", 64'(dram_req_rw), 64'd1);
    chk("full_wr_tag", 64'(dram_req_tag), 64'd0);
    tick();
    set_lane(1, 1'b0, 1'b0, '0, '0, '0, '0);
    core_rsp_ready = 4'hF;
    do_rsp(3'd5, 32'h5500_0000);
    chk("full_rsp_valid", 64'(core_rsp_valid), 64'h1);
    chk("full_still_blocked", 64'(core_req_ready), 64'd0);
    tick();
    chk("full_reissue_gnt", 64'(core_req_ready), 64'h1);
    chk("full_reissue_tag", 64'(dram_req_tag), 64'd5);
    tick();
    core_req_valid = '0;

    // Out-of-order responses
    do_reset();
    set_lane(0, 1'b1, 1'b0, 30'h21, 4'hF, '0, 3'd1); #1;
    chk("ooo_t0", 64'(dram_req_tag), 64'd0); tick();
    set_lane(0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_lane(1, 1'b1, 1'b0, 30'h32, 4'hF, '0, 3'd2); #1;
    chk("ooo_t1", 64'(dram_req_tag), 64'd1); tick();
    set_lane(1, 1'b0, 1'b0, '0, '0, '0, '0);
    set_lane(2, 1'b1, 1'b0, 30'h47, 4'hF, '0, 3'd6); #1;
    chk("ooo_t2", 64'(dram_req_tag), 64'd2); tick();
    set_lane(2, 1'b0, 1'b0, '0, '0, '0, '0);
    set_lane(3, 1'b1, 1'b0, 30'h5F, 4'hF, '0, 3'd7); #1;
    chk("ooo_t3", 64'(dram_req_tag), 64'd3); tick();
    set_lane(3, 1'b0, 1'b0, '0, '0, '0, '0);
    core_rsp_ready = 4'hF;
    do_rsp(3'd3, 32'h3300_0000);
    chk("ooo_r3_valid", 64'(core_rsp_valid), 64'h8);
    chk("ooo_r3_tag", 64'(core_rsp_tag[11:9]), 64'd7);
    chk("ooo_r3_data", 64'(core_rsp_data[127:96]), 64'h3300_000F);
    tick();
    do_rsp(3'd0, 32'h1100_0000);
    chk("ooo_r0_valid", 64'(core_rsp_valid), 64'h1);
    chk("ooo_r0_tag", 64'(core_rsp_tag[2:0]), 64'd1);
    chk("ooo_r0_data", 64'(core_rsp_data[31:0]), 64'h1100_0001);
    tick();
    do_rsp(3'd1, 32'h2200_0000);
    chk("ooo_r1_valid", 64'(core_rsp_valid), 64'h2);
    chk("ooo_r1_tag", 64'(core_rsp_tag[5:3]), 64'd2);
    chk("ooo_r1_data", 64'(core_rsp_data[63:32]), 64'h2200_0002);
    tick();
    do_rsp(3'd5, 32'h9900_0000);
    chk("ooo_drop_valid", 64'(core_rsp_valid), 64'd0);
    chk("ooo_drop_ready", 64'(dram_rsp_ready), 64'd1);
    tick();

    // Flush with two reads outstanding
    do_reset();
    core_rsp_ready = 4'hF;
    set_lane(0, 1'b1, 1'b0, 30'h0, 4'hF, '0, 3'd3); #1;
    tick(); tick();
    set_lane(0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_lane(1, 1'b1, 1'b0, 30'h10, 4'hF, '0, 3'd4);
    flush = 1'b1; #1;
    chk("fl_pulse_gnt", 64'(core_req_ready), 64'd0);
    chk("fl_pulse_valid", 64'(dram_req_valid), 64'd0);
    tick();
    flush = 1'b0; #1;
    chk("fl_busy", 64'(busy), 64'd1);
    chk("fl_no_gnt", 64'(core_req_ready), 64'd0);
    chk("fl_no_valid", 64'(dram_req_valid), 64'd0);
    do_rsp(3'd0, 32'h4400_0000);
    chk("fl_rsp0_valid", 64'(core_rsp_valid), 64'h1);
    tick();
    chk("fl_busy_mid", 64'(busy), 64'd1);
    do_rsp(3'd1, 32'h4500_0000);
    chk("fl_rsp1_valid", 64'(core_rsp_valid), 64'h1);
    chk("fl_busy_last", 64'(busy), 64'd1);
    chk("fl_no_gnt_last", 64'(core_req_ready), 64'd0);
    tick();
    chk("fl_busy_fall", 64'(busy), 64'd0);
    chk("fl_held_gnt", 64'(core_req_ready), 64'h2);
    chk("fl_held_tag", 64'(dram_req_tag), 64'd0);
    tick();
    core_req_valid = '0;

    // Reset with three reads outstanding, then a late response
    do_reset();
    set_lane(0, 1'b1, 1'b0, 30'h0, 4'hF, '0, 3'd2); #1;
    tick(); tick(); tick();
    core_req_valid = '0;
    do_reset();
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rsp_valid", 64'(core_rsp_valid), 64'd0);
    chk("mr_rsp_ready", 64'(dram_rsp_ready), 64'd1);
    do_rsp(3'd1, 32'h7700_0000);
    chk("mr_late_dropped", 64'(core_rsp_valid), 64'd0);
    chk("mr_late_ready", 64'(dram_rsp_ready), 64'd1);
    set_lane(0, 1'b1, 1'b0, 30'h0, 4'hF, '0, 3'd2); #1;
    chk("mr_fresh_tag", 64'(dram_req_tag), 64'd0);
    tick();
    core_req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
